// File: rtl/ifetch_queue_if.sv
// Bundle of ROM-side and core-side signals for the instruction prefetch queue.
// Core side is valid/ready: an entry moves when out_valid and out_ready are both high at a rising edge.
interface ifetch_queue_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 10,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DATA_W-1:0]  imem_rdata;
    logic               out_valid;
    logic [DATA_W-1:0]  out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_ready;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [CW-1:0]      count;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
        input  imem_rdata, out_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
        output imem_rdata, out_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch: sequential fetch from a 1-cycle ROM into a small FIFO,
// delivered to the core by valid/ready, with redirect flushing everything in flight.
module ifetch_queue #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              IMEM_AW  = 10,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          CLK,
    input logic          RESET,
    ifetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_q;
    logic              req_q;
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;

    logic              issue;
    logic              push;
    logic              pop;
    logic              valid;
    logic [CW:0]       inflight;
    logic [ADDR_W-1:0] target;

    // Occupancy plus the read still in flight bounds issue, so a push never finds the FIFO full.
    always_comb begin
        inflight = {1'b0, cnt} + {{CW{1'b0}}, req_q};
        issue    = ~RESET & ~bus.redirect & (inflight < (CW+1)'(DEPTH));
        push     = req_q & ~bus.redirect;
        valid    = (cnt != '0) & ~bus.redirect & ~RESET;
        pop      = valid & bus.out_ready;
        target   = bus.redirect_pc & ~ADDR_W'(3);
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc[IMEM_AW+1:2];
    assign bus.out_valid = valid;
    assign bus.out_instr = RESET ? '0 : instr_mem[rd_ptr];
    assign bus.out_pc    = RESET ? '0 : pc_mem[rd_ptr];
    assign bus.count     = cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc <= RESET_PC;
            pc_q     <= '0;
            req_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (bus.redirect) begin
            // The response arriving this cycle belongs to the old path and is simply not pushed.
            fetch_pc <= target;
            req_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
        end else begin
            req_q <= issue;
            if (issue) begin
                pc_q     <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (push) begin
                instr_mem[wr_ptr] <= bus.imem_rdata;
                pc_mem[wr_ptr]    <= pc_q;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push) begin
            assert (cnt != CW'(DEPTH));
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and randomized bench for ifetch_queue: ROM model, expected-PC scoreboard,
// latency and redirect checks derived from the fetch rules.
module tb_ifetch_queue;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int IMEM_AW = 10;
    localparam int DEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic CLK;
    logic RESET;
    int   errors = 0;
    int   checks = 0;

    logic [DATA_W-1:0] rom [1024];
    logic [ADDR_W-1:0] exp_q [$];

    ifetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMEM_AW(IMEM_AW), .DEPTH(DEPTH)) bus ();

    ifetch_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMEM_AW(IMEM_AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous ROM: data for the address presented with imem_req appears after the edge.
    always @(posedge CLK) begin
        if (bus.imem_req) bus.imem_rdata <= rom[bus.imem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refill(input logic [ADDR_W-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(start + ADDR_W'(4 * i));
    endtask

    function automatic logic [DATA_W-1:0] rom_at(input logic [ADDR_W-1:0] pc);
        logic [IMEM_AW-1:0] a;
        a = pc[IMEM_AW+1:2];
        return rom[a];
    endfunction

    // Finish the current cycle: score any handshake, note flushes, step past the edge.
    task automatic tick();
        logic [ADDR_W-1:0] pc_exp;
        @(negedge CLK);
        if (bus.out_valid && bus.out_ready) begin
            pc_exp = exp_q.pop_front();
            chk("sb_pc", bus.out_pc, pc_exp);
            chk("sb_instr", bus.out_instr, rom_at(pc_exp));
            if (exp_q.size() < 4) exp_q.push_back(exp_q[exp_q.size()-1] + 32'd4);
        end
        if (RESET) refill(RESET_PC);
        else if (bus.redirect) refill(bus.redirect_pc & ~32'd3);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int since;
        bit evt;
        for (int i = 0; i < 1024; i++) rom[i] = 32'(i);
        RESET = 1'b1;
        bus.out_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        refill(RESET_PC);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_instr", bus.out_instr, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_req", bus.imem_req, 0);

        // Streaming with out_ready held high: first valid two cycles after release, no gaps.
        RESET = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("t1_c0_req", bus.imem_req, 1);
        chk("t1_c0_addr", bus.imem_addr, 0);
        chk("t1_c0_valid", bus.out_valid, 0);
        tick();
        chk("t1_c1_valid", bus.out_valid, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("t1_valid", bus.out_valid, 1);
            chk("t1_pc", bus.out_pc, 4 * i);
            chk("t1_instr", bus.out_instr, i);
            chk("t1_count", bus.count, 1);
            tick();
        end

        // Back-pressure: fill to DEPTH, issue stops, release drains in order.
        RESET = 1'b1;
        #1;
        tick();
        RESET = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("t2_req", bus.imem_req, (k < 4) ? 1 : 0);
            chk("t2_count", bus.count, (k < 2) ? 0 : ((k - 1 > 4) ? 4 : k - 1));
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        for (int j = 0; j < 5; j++) begin
            chk("t2_valid", bus.out_valid, 1);
            chk("t2_pc", bus.out_pc, 4 * j);
            tick();
        end

        // Redirect while count=3 with a read in flight.
        RESET = 1'b1;
        #1;
        tick();
        RESET = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        repeat (4) tick();
        chk("t3_count_pre", bus.count, 3);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h103;
        #1;
        chk("t3_req_in_redirect", bus.imem_req, 0);
        chk("t3_valid_in_redirect", bus.out_valid, 0);
        tick();
        bus.redirect = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("t3_count_flushed", bus.count, 0);
        chk("t3_valid_flushed", bus.out_valid, 0);
        chk("t3_req", bus.imem_req, 1);
        chk("t3_addr", bus.imem_addr, 32'h40);
        tick();
        tick();
        chk("t3_valid", bus.out_valid, 1);
        chk("t3_pc", bus.out_pc, 32'h100);
        chk("t3_instr", bus.out_instr, 32'h40);
        tick();

        // Two consecutive redirects: the second target wins.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h20;
        #1;
        tick();
        bus.redirect_pc = 32'h80;
        #1;
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("t4_addr", bus.imem_addr, 32'h20);
        chk("t4_req", bus.imem_req, 1);
        tick();
        tick();
        chk("t4_valid", bus.out_valid, 1);
        chk("t4_pc", bus.out_pc, 32'h80);
        tick();

        // Address wrap at the top of the PC space.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        #1;
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("t5_addr_top", bus.imem_addr, 32'h3FF);
        tick();
        chk("t5_addr_wrap", bus.imem_addr, 0);
        tick();
        chk("t5_valid", bus.out_valid, 1);
        chk("t5_pc_top", bus.out_pc, 32'hFFFF_FFFC);
        chk("t5_instr_top", bus.out_instr, 32'h3FF);
        tick();
        chk("t5_pc_wrap", bus.out_pc, 0);
        chk("t5_instr_wrap", bus.out_instr, 0);

        // Mid-stream reset pulse with count=2.
        bus.out_ready = 1'b0;
        #1;
        tick();
        chk("t6_count_pre", bus.count, 2);
        RESET = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("t6_req_in_reset", bus.imem_req, 0);
        chk("t6_valid_in_reset", bus.out_valid, 0);
        chk("t6_instr_in_reset", bus.out_instr, 0);
        chk("t6_pc_in_reset", bus.out_pc, 0);
        tick();
        RESET = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("t6_count", bus.count, 0);
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_pc_cleared", bus.out_pc, 0);
        chk("t6_req", bus.imem_req, 1);
        chk("t6_addr", bus.imem_addr, 0);
        tick();
        bus.out_ready = 1'b1;
        #1;
        chk("t6_c1_valid", bus.out_valid, 0);
        tick();
        chk("t6_c2_valid", bus.out_valid, 1);
        chk("t6_c2_pc", bus.out_pc, 0);
        chk("t6_c2_instr", bus.out_instr, 0);
        tick();

        // Random traffic against a fresh random ROM image.
        RESET = 1'b1;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        #1;
        tick();
        since = 1;
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            RESET = (r == 0);
            bus.redirect = (r >= 1 && r <= 8);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                          : $urandom;
            bus.out_ready = 1'($urandom_range(0, 1));
            evt = RESET || bus.redirect;
            #1;
            chk("rnd_count_bound", (bus.count <= DEPTH) ? 1 : 0, 1);
            if (evt) begin
                chk("rnd_valid_flush", bus.out_valid, 0);
                chk("rnd_req_flush", bus.imem_req, 0);
            end else if (since >= 3) begin
                chk("rnd_valid_live", bus.out_valid, 1);
            end
            tick();
            since = evt ? 1 : since + 1;
        end
        RESET = 1'b0;
        bus.redirect = 1'b0;
        bus.out_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
